irq_request_latch: RTL and testbench

- Front-end stage of the 8259 PIC core; sits directly upstream of the priority resolver and in-service logic.
- Synchronises the eight asynchronous IR lines to the core clock and applies edge or level triggering per ICW1 LTIM.
- Holds the Interrupt Request Register (IRR), applies the IMR, and clears IRR bits on the first INTA acknowledge.
- Flags spurious acknowledges, i.e. an acknowledge for a request that has since dropped.

---
 rtl/irq_request_latch.sv | 48 ++++
 tb/tb_irq_request_latch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/irq_request_latch.sv
// irq_request_latch: 8259 IRR front end with IR synchronisation, edge/level triggering, masking and spurious-ack detection.
module irq_request_latch #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int IDW        = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               ltim,
  input  logic               init_clear,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               ack_valid,
  input  logic [IDW-1:0]     ack_id,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] irr_masked,
  output logic               int_pending,
  output logic               spurious
);
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] ir_s, ir_d_q, irr_q, irr_d, ack_dec;
  logic               spurious_q, spurious_d;
  assign ir_s = sync_q[SYNC_STAGES-1];
  // Out-of-range ack_id decodes to no bit, so it clears nothing and reads as spurious.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) ack_dec[i] = ack_valid && (ack_id == IDW'(i));
    irr_d      = init_clear ? '0 : ltim ? ir_s : ((ir_s & ~ir_d_q) | (irr_q & ir_s & ~ack_dec));
    spurious_d = ack_valid && !(|(ack_dec & irr_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      ir_d_q     <= '0;
      irr_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      sync_q[0] <= ir_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      ir_d_q     <= ir_s;
      irr_q      <= irr_d;
      spurious_q <= spurious_d;
    end
  end
  assign irr         = irr_q;
  assign irr_masked  = irr_q & ~mask;
  assign int_pending = |irr_masked;
  assign spurious    = spurious_q;
endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch: directed plan plus random traffic checked against a history-based IRR reference model.
module tb_irq_request_latch;
  localparam int N = 8;
  localparam int S = 2;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ir_in = '0;
  logic [N-1:0] mask = '0;
  logic         ltim = 1'b0;
  logic         init_clear = 1'b0;
  logic         ack_valid = 1'b0;
  logic [2:0]   ack_id = '0;
  logic [N-1:0] irr, irr_masked;
  logic         int_pending, spurious;
  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] hist [$];
  logic [N-1:0] m_irr;
  logic         m_sp;

  irq_request_latch #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .ltim(ltim), .init_clear(init_clear),
    .mask(mask), .ack_valid(ack_valid), .ack_id(ack_id), .irr(irr),
    .irr_masked(irr_masked), .int_pending(int_pending), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // hist holds ir_in as sampled at each past edge; the line as seen by the IRR logic is that sample S edges late.
  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k <= S; k++) hist.push_back('0);
    m_irr = '0;
    m_sp  = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] s, d, nx;
    s = hist[$-(S-1)];
    d = hist[$-S];
    for (int i = 0; i < N; i++) begin
      if (init_clear)                      nx[i] = 1'b0;
      else if (ltim)                       nx[i] = s[i];
      else if (s[i] && !d[i])              nx[i] = 1'b1;
      else if (!s[i])                      nx[i] = 1'b0;
      else if (ack_valid && ack_id == i)   nx[i] = 1'b0;
      else                                 nx[i] = m_irr[i];
    end
    m_sp  = ack_valid && (int'(ack_id) >= N || !m_irr[ack_id]);
    m_irr = nx;
    hist.push_back(ir_in);
    void'(hist.pop_front());
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("irr", irr, m_irr);
    chk("spurious", spurious, m_sp);
    chk("irr_masked", irr_masked, m_irr & ~mask);
    chk("int_pending", int_pending, |(m_irr & ~mask));
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_irr", irr, 0);
    chk("reset_spurious", spurious, 0);
    chk("reset_int_pending", int_pending, 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    // edge request, latency and acknowledge
    ir_in = 8'h10;
    repeat (3) cyc();
    chk("edge_latch_irr", irr, 8'h10);
    chk("edge_latch_int", int_pending, 1);
    ack_valid = 1'b1; ack_id = 3'd4;
    cyc();
    ack_valid = 1'b0;
    chk("edge_ack_irr", irr, 8'h00);
    chk("edge_ack_spurious", spurious, 0);
    repeat (3) cyc();
    chk("edge_held_no_rerequest", irr, 8'h00);
    ir_in = 8'h00;
    repeat (3) cyc();
    ir_in = 8'h10;
    repeat (3) cyc();
    chk("edge_rerise_irr", irr, 8'h10);
    // level mode
    ltim = 1'b1; init_clear = 1'b1; ir_in = 8'h81;
    cyc();
    init_clear = 1'b0;
    repeat (3) cyc();
    chk("level_irr", irr, 8'h81);
    ack_valid = 1'b1; ack_id = 3'd7;
    cyc();
    ack_valid = 1'b0;
    cyc();
    chk("level_ack_reassert", irr, 8'h81);
    ir_in = 8'h00;
    repeat (3) cyc();
    chk("level_drop_irr", irr, 8'h00);
    // withdrawn request and spurious acknowledge
    ltim = 1'b0; init_clear = 1'b1;
    cyc();
    init_clear = 1'b0; ir_in = 8'h04;
    repeat (3) cyc();
    chk("withdraw_latched", irr, 8'h04);
    ir_in = 8'h00;
    repeat (3) cyc();
    chk("withdraw_lost", irr, 8'h00);
    ack_valid = 1'b1; ack_id = 3'd2;
    cyc();
    ack_valid = 1'b0;
    chk("spurious_pulse", spurious, 1);
    cyc();
    chk("spurious_one_cycle", spurious, 0);
    // masking
    mask = 8'h10; ir_in = 8'h10;
    repeat (3) cyc();
    chk("mask_irr", irr, 8'h10);
    chk("mask_irr_masked", irr_masked, 8'h00);
    chk("mask_int_pending", int_pending, 0);
    mask = 8'h00;
    #1;
    chk("unmask_int_pending", int_pending, 1);
    chk("unmask_irr", irr, 8'h10);
    // init_clear with lines already high
    ir_in = 8'hFF;
    repeat (3) cyc();
    init_clear = 1'b1;
    cyc();
    init_clear = 1'b0;
    chk("init_clear_irr", irr, 8'h00);
    repeat (4) cyc();
    chk("init_clear_no_edge", irr, 8'h00);
    // asynchronous reset mid-operation
    ir_in = 8'h00;
    repeat (3) cyc();
    ir_in = 8'h3C;
    repeat (3) cyc();
    chk("pre_reset_irr", irr, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_irr", irr, 8'h00);
    chk("async_reset_spurious", spurious, 0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (4) cyc();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      ir_in      = ir_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 7) == 0) mask = N'($urandom);
      ack_valid  = ($urandom_range(0, 3) == 0);
      ack_id     = 3'($urandom_range(0, 7));
      init_clear = ($urandom_range(0, 31) == 0);
      if (init_clear) ltim = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
